multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have these ports, in this order:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset: synchronous, active-low.
- op  in  7  instruction opcode, taken from the instruction register.
- funct3  in  3  instruction funct3, taken from the instruction register.
- zero  in  1  ALU result == 0.
- alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome).
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = result.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register and OldPC enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  to the ALU decoder: 00 = add, 01 = branch compare, 10 = funct-decoded.
- illegal  out  1  illegal instruction trap.
- state  out  4  current state, for debug.
REQ-002 There are no parameters.

Function
REQ-003 A single state register SHALL hold the FSM state; all outputs SHALL be combinational from state, zero, alu_lsb and mem_ready.
REQ-004 The state encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, JALR_LINK=12, TRAP=15.
REQ-005 Any output not listed for a state SHALL be 0.
REQ-006 FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, and ir_write=pc_write=mem_ready; it SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-007 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00, and SHALL go to:
- MEMADR for op 0000011 or 0100011;
- EXECR for op 0110011;
- EXECI for op 0010011;
- BRANCH for op 1100011 with funct3 not in {010, 011};
- JAL for op 1101111;
- JALR for op 1100111;
- TRAP for any other op, or for a branch with funct3 010 or 011.
REQ-008 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00, and SHALL go to MEMREAD if op=0000011, else to MEMWRITE.
REQ-009 MEMREAD SHALL drive adr_src=1, result_src=00; it SHALL hold while mem_ready=0 and go to MEMWB when mem_ready=1.
REQ-010 MEMWB SHALL drive result_src=01, reg_write=1, then go to FETCH.
REQ-011 MEMWRITE SHALL drive adr_src=1, result_src=00, mem_write=1 for every cycle until mem_ready=1, then go to FETCH.
REQ-012 EXECR SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10, then go to ALUWB.
REQ-013 EXECI SHALL drive alu_src_a=10, alu_src_b=01, alu_op=10, then go to ALUWB.
REQ-014 ALUWB SHALL drive result_src=00, reg_write=1, then go to FETCH.
REQ-015 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, and SHALL set pc_write=taken, where taken is:
- funct3 000: zero;
- funct3 001: ~zero;
- funct3 100 or 110: alu_lsb;
- funct3 101 or 111: ~alu_lsb.
BRANCH SHALL then go to FETCH.
REQ-016 JAL SHALL drive alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, then go to ALUWB.
REQ-017 JALR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00, result_src=10, pc_write=1, then go to JALR_LINK.
REQ-018 JALR_LINK SHALL drive alu_src_a=01, alu_src_b=10, alu_op=00, then go to ALUWB.
REQ-019 TRAP SHALL drive illegal=1 with all enables 0, and SHALL remain in TRAP until reset.
REQ-020 Unused encodings 13 and 14 SHALL go to TRAP on the next edge.
REQ-021 Instruction latencies from FETCH entry, with mem_ready=1 throughout, SHALL be:
- R-type, I-type, branch: 4, 4 and 3 cycles respectively;
- lw: 5 cycles; sw: 4 cycles; jal: 4 cycles; jalr: 5 cycles.
- Each wait cycle adds 1 cycle.
REQ-022 mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE; it SHALL be ignored in all other states.

Reset
REQ-023 reset_n=0 at a rising clk edge SHALL force state to FETCH, regardless of the current state, including TRAP.
REQ-024 While reset_n=0, outputs SHALL show FETCH values, and ir_write and pc_write SHALL still follow mem_ready.
REQ-025 Reset asserted during MEMWRITE SHALL drop mem_write at the edge where reset is sampled.
REQ-026 No X SHALL appear on any output after the first reset edge.

Verification
REQ-027 Reset, then add (op 0110011) with mem_ready=1 -> state sequence 0,1,6,8,0; reg_write=1 only in state 8; alu_op=10 in state 6.
REQ-028 lw (op 0000011) with mem_ready low for 2 cycles in MEMREAD -> state sequence 0,1,2,3,3,3,4,0; adr_src=1 in all state-3 cycles; reg_write=1 with result_src=01 in state 4.
REQ-029 bne (funct3 001) in BRANCH -> with zero=0, pc_write=1; with zero=1, pc_write=0. bge (funct3 101) with alu_lsb=1 -> pc_write=0.
REQ-030 jalr (op 1100111) -> state sequence 0,1,11,12,8,0; pc_write=1 in state 11 only; alu_src_a=01 and alu_src_b=10 in state 12.
REQ-031 Illegal instructions -> op 1111111 at DECODE gives state 15 and illegal=1; state holds for 10 cycles; reset_n=0 for one edge returns state to 0. Branch with funct3 010 also gives TRAP.
REQ-032 sw (op 0100011) with mem_ready=0 and reset_n=0 asserted in state 5 -> next state 0 and mem_write=0; a FETCH stall with mem_ready=0 keeps ir_write=0 and pc_write=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: one state register, outputs decoded
// combinationally from the state plus the ALU flags and memory handshake.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       alu_lsb,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECR     = 4'd6,
    EXECI     = 4'd7,
    ALUWB     = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    JALR      = 4'd11,
    JALR_LINK = 4'd12,
    TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t state_reg;
  state_t state_next;
  logic   taken;
  logic   bad_branch;

  assign state = state_reg;

  // funct3 010/011 are not branch encodings; they trap at decode.
  assign bad_branch = (funct3 == 3'b010) || (funct3 == 3'b011);

  // Branch condition from the ALU compare flags.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:          taken = zero;
      3'b001:          taken = ~zero;
      3'b100, 3'b110:  taken = alu_lsb;
      3'b101, 3'b111:  taken = ~alu_lsb;
      default:         taken = 1'b0;
    endcase
  end

  // Next-state logic; mem_ready only matters in the memory states.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:     state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BRANCH:         state_next = bad_branch ? TRAP : BRANCH;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          default:           state_next = TRAP;
        endcase
      end
      MEMADR:    state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:   state_next = mem_ready ? MEMWB : MEMREAD;
      MEMWB:     state_next = FETCH;
      MEMWRITE:  state_next = mem_ready ? FETCH : MEMWRITE;
      EXECR:     state_next = ALUWB;
      EXECI:     state_next = ALUWB;
      ALUWB:     state_next = FETCH;
      BRANCH:    state_next = FETCH;
      JAL:       state_next = ALUWB;
      JALR:      state_next = JALR_LINK;
      JALR_LINK: state_next = ALUWB;
      TRAP:      state_next = TRAP;
      default:   state_next = TRAP;
    endcase
  end

  // State register; reset wins from any state, TRAP included.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output decode; anything not set for a state stays 0.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (state_reg)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = taken;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      JALR_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: table-driven instruction walks
// plus hand-written wait-state, trap and reset corner cases.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       alu_lsb;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .alu_lsb    (alu_lsb),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            zero;
    logic            lsb;
    int              len;
    logic            taken;
    logic [0:7][3:0] seq;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packed view of every control output:
  // pc_write adr_src mem_write ir_write reg_write result_src alu_src_a alu_src_b alu_op illegal
  function automatic logic [13:0] dut_ctrl();
    return {pc_write, adr_src, mem_write, ir_write, reg_write,
            result_src, alu_src_a, alu_src_b, alu_op, illegal};
  endfunction

  // Hand-written expected control word per state, mem_ready=1.
  function automatic logic [13:0] exp_ctrl(input logic [3:0] st, input logic tk);
    case (st)
      4'd0:    return 14'b1_0_0_1_0_10_00_10_00_0;
      4'd1:    return 14'b0_0_0_0_0_00_01_01_00_0;
      4'd2:    return 14'b0_0_0_0_0_00_10_01_00_0;
      4'd3:    return 14'b0_1_0_0_0_00_00_00_00_0;
      4'd4:    return 14'b0_0_0_0_1_01_00_00_00_0;
      4'd5:    return 14'b0_1_1_0_0_00_00_00_00_0;
      4'd6:    return 14'b0_0_0_0_0_00_10_00_10_0;
      4'd7:    return 14'b0_0_0_0_0_00_10_01_10_0;
      4'd8:    return 14'b0_0_0_0_1_00_00_00_00_0;
      4'd9:    return {tk, 13'b0_0_0_0_00_10_00_01_0};
      4'd10:   return 14'b1_0_0_0_0_00_01_10_00_0;
      4'd11:   return 14'b1_0_0_0_0_10_10_01_00_0;
      4'd12:   return 14'b0_0_0_0_0_00_01_10_00_0;
      4'd15:   return 14'b0_0_0_0_0_00_00_00_00_1;
      default: return 14'b0;
    endcase
  endfunction

  initial begin
    reset_n   = 1'b0;
    op        = 7'b0;
    funct3    = 3'b0;
    zero      = 1'b0;
    alu_lsb   = 1'b0;
    mem_ready = 1'b1;

    vecs.push_back('{"add",   7'b0110011, 3'b000, 1'b0, 1'b0, 5, 1'b0, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 12'd0}});
    vecs.push_back('{"addi",  7'b0010011, 3'b000, 1'b0, 1'b0, 5, 1'b0, {4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 12'd0}});
    vecs.push_back('{"lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 6, 1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 8'd0}});
    vecs.push_back('{"sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 5, 1'b0, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 12'd0}});
    vecs.push_back('{"beq_t", 7'b1100011, 3'b000, 1'b1, 1'b0, 4, 1'b1, {4'd0, 4'd1, 4'd9, 4'd0, 16'd0}});
    vecs.push_back('{"beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 4, 1'b0, {4'd0, 4'd1, 4'd9, 4'd0, 16'd0}});
    vecs.push_back('{"bne_t", 7'b1100011, 3'b001, 1'b0, 1'b0, 4, 1'b1, {4'd0, 4'd1, 4'd9, 4'd0, 16'd0}});
    vecs.push_back('{"bne_n", 7'b1100011, 3'b001, 1'b1, 1'b0, 4, 1'b0, {4'd0, 4'd1, 4'd9, 4'd0, 16'd0}});
    vecs.push_back('{"blt_t", 7'b1100011, 3'b100, 1'b0, 1'b1, 4, 1'b1, {4'd0, 4'd1, 4'd9, 4'd0, 16'd0}});
    vecs.push_back('{"bge_n", 7'b1100011, 3'b101, 1'b0, 1'b1, 4, 1'b0, {4'd0, 4'd1, 4'd9, 4'd0, 16'd0}});
    vecs.push_back('{"bltu_n",7'b1100011, 3'b110, 1'b1, 1'b0, 4, 1'b0, {4'd0, 4'd1, 4'd9, 4'd0, 16'd0}});
    vecs.push_back('{"bgeu_t",7'b1100011, 3'b111, 1'b1, 1'b0, 4, 1'b1, {4'd0, 4'd1, 4'd9, 4'd0, 16'd0}});
    vecs.push_back('{"jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 5, 1'b0, {4'd0, 4'd1, 4'd10, 4'd8, 4'd0, 12'd0}});
    vecs.push_back('{"jalr",  7'b1100111, 3'b000, 1'b0, 1'b0, 6, 1'b0, {4'd0, 4'd1, 4'd11, 4'd12, 4'd8, 4'd0, 8'd0}});
    vecs.push_back('{"ill_op",7'b1111111, 3'b000, 1'b0, 1'b0, 4, 1'b0, {4'd0, 4'd1, 4'd15, 4'd15, 16'd0}});
    vecs.push_back('{"br_010",7'b1100011, 3'b010, 1'b0, 1'b0, 4, 1'b0, {4'd0, 4'd1, 4'd15, 4'd15, 16'd0}});
    vecs.push_back('{"br_011",7'b1100011, 3'b011, 1'b0, 1'b0, 4, 1'b0, {4'd0, 4'd1, 4'd15, 4'd15, 16'd0}});

    // Table-driven walks, mem_ready=1 throughout.
    foreach (vecs[i]) begin
      reset_n   = 1'b0;
      op        = vecs[i].op;
      funct3    = vecs[i].f3;
      zero      = vecs[i].zero;
      alu_lsb   = vecs[i].lsb;
      mem_ready = 1'b1;
      tick();
      reset_n = 1'b1;
      for (int s = 0; s < vecs[i].len; s++) begin
        check({vecs[i].name, "_state"}, {28'd0, state}, {28'd0, vecs[i].seq[s]});
        check({vecs[i].name, "_ctrl"}, {18'd0, dut_ctrl()},
              {18'd0, exp_ctrl(vecs[i].seq[s], vecs[i].taken)});
        if (s < vecs[i].len - 1) tick();
      end
      $display("vector %s: %0d steps walked", vecs[i].name, vecs[i].len);
    end

    // lw with mem_ready low through DECODE/MEMADR (ignored) and two MEMREAD waits.
    reset_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    check("lw_wait_s0", {28'd0, state}, 32'd0);
    tick(); mem_ready = 1'b0; #1;
    check("lw_wait_s1", {28'd0, state}, 32'd1);
    tick();
    check("lw_wait_s2", {28'd0, state}, 32'd2);
    tick();
    check("lw_wait_s3a", {28'd0, state}, 32'd3);
    check("lw_wait_adr_a", {31'd0, adr_src}, 32'd1);
    tick();
    check("lw_wait_s3b", {28'd0, state}, 32'd3);
    check("lw_wait_adr_b", {31'd0, adr_src}, 32'd1);
    tick(); mem_ready = 1'b1; #1;
    check("lw_wait_s3c", {28'd0, state}, 32'd3);
    check("lw_wait_adr_c", {31'd0, adr_src}, 32'd1);
    tick();
    check("lw_wait_s4", {28'd0, state}, 32'd4);
    check("lw_wait_wb", {30'd0, reg_write, result_src}, 32'b101);
    tick();
    check("lw_wait_s0_end", {28'd0, state}, 32'd0);
    $display("sequence lw with wait states done");

    // Illegal opcode: TRAP holds for 10 cycles, then one reset edge recovers.
    reset_n = 1'b0; op = 7'b1111111; funct3 = 3'b000; mem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    check("trap_enter", {28'd0, state}, 32'd15);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("trap_hold", {28'd0, state}, 32'd15);
      check("trap_illegal", {31'd0, illegal}, 32'd1);
      check("trap_enables", {27'd0, pc_write, mem_write, ir_write, reg_write, adr_src}, 32'd0);
    end
    reset_n = 1'b0;
    tick();
    check("trap_reset", {28'd0, state}, 32'd0);
    check("trap_reset_ill", {31'd0, illegal}, 32'd0);
    reset_n = 1'b1;
    $display("sequence trap hold and recovery done");

    // sw stalled in MEMWRITE, reset drops mem_write; FETCH under reset follows mem_ready.
    reset_n = 1'b0; op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick(); tick(); mem_ready = 1'b0; tick();
    check("sw_s5", {28'd0, state}, 32'd5);
    check("sw_mw_a", {31'd0, mem_write}, 32'd1);
    tick();
    check("sw_s5_hold", {28'd0, state}, 32'd5);
    check("sw_mw_b", {31'd0, mem_write}, 32'd1);
    reset_n = 1'b0;
    tick();
    check("sw_rst_state", {28'd0, state}, 32'd0);
    check("sw_rst_mw", {31'd0, mem_write}, 32'd0);
    check("rst_stall_irpc", {30'd0, ir_write, pc_write}, 32'd0);
    mem_ready = 1'b1; #1;
    check("rst_ready_irpc", {30'd0, ir_write, pc_write}, 32'b11);
    check("rst_ctrl", {18'd0, dut_ctrl()}, {18'd0, exp_ctrl(4'd0, 1'b0)});
    reset_n = 1'b1; mem_ready = 1'b0; #1;
    tick();
    check("fetch_stall_state", {28'd0, state}, 32'd0);
    check("fetch_stall_irpc", {30'd0, ir_write, pc_write}, 32'd0);
    mem_ready = 1'b1;
    tick();
    check("fetch_release", {28'd0, state}, 32'd1);
    $display("sequence sw reset and fetch stall done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
